// File: rtl/vending_machine_multi.sv
// Multi-product vending controller: bounded coin credit, per-product prices, one-coin-per-ack change return.
// Optional per-product stock counters are built when VM_STOCK_EN is defined.
module vending_machine_multi #(
  parameter int NUM_PRODUCTS = 4,
  parameter int SEL_W = 2,
  parameter int CREDIT_W = 8,
  parameter int MAX_CREDIT = 100,
  parameter logic [NUM_PRODUCTS*CREDIT_W-1:0] PRICE_LIST = 32'h32_23_19_0F,
  parameter int STOCK_W = 4,
  parameter int STOCK_INIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    coin5,
  input  logic                    coin10,
  input  logic                    coin25,
  input  logic                    select,
  input  logic [SEL_W-1:0]        sel_id,
  input  logic                    cancel,
  input  logic                    restock,
  input  logic                    change_ack,
  output logic                    dispense,
  output logic [SEL_W-1:0]        dispense_id,
  output logic                    change_valid,
  output logic [1:0]              change_coin,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    coin_reject,
  output logic                    busy,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;

  state_t                state_reg, state_next;
  logic [CREDIT_W-1:0]   credit_reg, credit_next;
  logic [SEL_W-1:0]      vend_id_reg, vend_id_next;
  logic                  dispense_reg, change_valid_reg, coin_reject_reg, busy_reg;
  logic [1:0]            change_coin_reg;
  logic                  reject_next;
  logic [NUM_PRODUCTS-1:0] sold_out_w;
  logic [CREDIT_W-1:0]   price_arr [NUM_PRODUCTS];
  logic [CREDIT_W-1:0]   sel_price, vend_price, coin_val;
  logic                  sel_ok, any_coin, one_coin;
  logic [CREDIT_W:0]     coin_sum;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] c);
    case (c)
      2'b01:   coin_value = CREDIT_W'(5);
      2'b10:   coin_value = CREDIT_W'(10);
      2'b11:   coin_value = CREDIT_W'(25);
      default: coin_value = '0;
    endcase
  endfunction

  // Greedy change: largest denomination not exceeding the remaining credit.
  function automatic logic [1:0] coin_for(input logic [CREDIT_W-1:0] c);
    if (c >= CREDIT_W'(25))      coin_for = 2'b11;
    else if (c >= CREDIT_W'(10)) coin_for = 2'b10;
    else if (c >= CREDIT_W'(5))  coin_for = 2'b01;
    else                         coin_for = 2'b00;
  endfunction

  for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_price
    assign price_arr[gi] = PRICE_LIST[gi*CREDIT_W +: CREDIT_W];
  end

  always_comb begin
    sel_price  = '0;
    sel_ok     = 1'b0;
    vend_price = '0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (sel_id == SEL_W'(i)) begin
        sel_price = price_arr[i];
        sel_ok    = !sold_out_w[i];
      end
      if (vend_id_reg == SEL_W'(i))
        vend_price = price_arr[i];
    end
  end

  assign any_coin = coin5 | coin10 | coin25;
  assign one_coin = (coin5 ^ coin10 ^ coin25) & ~(coin5 & coin10 & coin25);
  assign coin_val = coin25 ? CREDIT_W'(25) : coin10 ? CREDIT_W'(10) : coin5 ? CREDIT_W'(5) : '0;
  assign coin_sum = {1'b0, credit_reg} + {1'b0, coin_val};

  always_comb begin
    state_next   = state_reg;
    credit_next  = credit_reg;
    vend_id_next = vend_id_reg;
    reject_next  = 1'b0;
    case (state_reg)
      IDLE, COLLECT: begin
        // Cancel beats coins beats select; a coin alongside an honoured cancel is refused.
        if (cancel && credit_reg != '0) begin
          state_next  = CHANGE;
          reject_next = any_coin;
        end else if (any_coin) begin
          if (!one_coin || coin_sum > (CREDIT_W+1)'(MAX_CREDIT)) begin
            reject_next = 1'b1;
          end else begin
            credit_next = coin_sum[CREDIT_W-1:0];
            state_next  = COLLECT;
          end
        end else if (select && sel_ok && credit_reg >= sel_price) begin
          state_next   = VEND;
          vend_id_next = sel_id;
        end
      end
      VEND: begin
        reject_next = any_coin;
        credit_next = credit_reg - vend_price;
        state_next  = (credit_next != '0) ? CHANGE : IDLE;
      end
      CHANGE: begin
        reject_next = any_coin;
        if (change_ack) begin
          credit_next = credit_reg - coin_value(change_coin_reg);
          if (credit_next == '0)
            state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered from next-state values so they line up with the state they describe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      credit_reg       <= '0;
      vend_id_reg      <= '0;
      dispense_reg     <= 1'b0;
      change_valid_reg <= 1'b0;
      change_coin_reg  <= 2'b00;
      coin_reject_reg  <= 1'b0;
      busy_reg         <= 1'b0;
    end else begin
      state_reg        <= state_next;
      credit_reg       <= credit_next;
      vend_id_reg      <= vend_id_next;
      dispense_reg     <= (state_next == VEND);
      change_valid_reg <= (state_next == CHANGE);
      change_coin_reg  <= (state_next == CHANGE) ? coin_for(credit_next) : 2'b00;
      coin_reject_reg  <= reject_next;
      busy_reg         <= (state_next == VEND) || (state_next == CHANGE);
    end
  end

`ifdef VM_STOCK_EN
  for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_stock
    logic [STOCK_W-1:0] stock_reg, stock_next;
    logic               empty_reg;

    // Restock overrides a same-cycle vend; the counter saturates at zero.
    always_comb begin
      stock_next = stock_reg;
      if (restock)
        stock_next = STOCK_W'(STOCK_INIT);
      else if (state_reg == VEND && vend_id_reg == SEL_W'(gi) && stock_reg != '0)
        stock_next = stock_reg - STOCK_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        stock_reg <= STOCK_W'(STOCK_INIT);
        empty_reg <= (STOCK_INIT == 0);
      end else begin
        stock_reg <= stock_next;
        empty_reg <= (stock_next == '0);
      end
    end

    assign sold_out_w[gi] = empty_reg;
  end
`else
  logic unused_restock;
  assign unused_restock = restock;
  assign sold_out_w     = '0;
`endif

  assign dispense     = dispense_reg;
  assign dispense_id  = vend_id_reg;
  assign change_valid = change_valid_reg;
  assign change_coin  = change_coin_reg;
  assign credit       = credit_reg;
  assign coin_reject  = coin_reject_reg;
  assign busy         = busy_reg;
  assign sold_out     = sold_out_w;

endmodule

// File: tb/tb_vending_machine_multi.sv
// Self-checking bench for vending_machine_multi: credit/refund model checked every cycle plus directed literal checks.
module tb_vending_machine_multi;
  localparam int NP = 4;
  localparam int STOCK_INIT = 1;
  localparam int MAXC = 100;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic coin5 = 0, coin10 = 0, coin25 = 0, select = 0, cancel = 0, restock = 0, change_ack = 0;
  logic [1:0] sel_id = '0;
  logic dispense, change_valid, coin_reject, busy;
  logic [1:0] dispense_id, change_coin;
  logic [7:0] credit;
  logic [NP-1:0] sold_out;

  int n_checks = 0;
  int n_fail = 0;

  vending_machine_multi #(.STOCK_INIT(STOCK_INIT)) dut (
    .clk(clk), .reset_n(reset_n), .coin5(coin5), .coin10(coin10), .coin25(coin25),
    .select(select), .sel_id(sel_id), .cancel(cancel), .restock(restock),
    .change_ack(change_ack), .dispense(dispense), .dispense_id(dispense_id),
    .change_valid(change_valid), .change_coin(change_coin), .credit(credit),
    .coin_reject(coin_reject), .busy(busy), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Behavioural model: credit as an integer, a pending-vend index and a refund flag.
  int  price [NP] = '{15, 25, 35, 50};
  int  m_credit, m_vend, m_stock [NP];
  bit  m_refund, m_reject;

  function automatic int greedy(input int c);
    return (c >= 25) ? 25 : (c >= 10) ? 10 : (c >= 5) ? 5 : 0;
  endfunction

  function automatic int code_of(input int v);
    return (v == 25) ? 3 : (v == 10) ? 2 : (v == 5) ? 1 : 0;
  endfunction

  function automatic bit empty(input int i);
`ifdef VM_STOCK_EN
    return m_stock[i] == 0;
`else
    return 1'b0;
`endif
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_credit = 0; m_vend = -1; m_refund = 0; m_reject = 0;
      foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
    end else begin
      int ncoin, val;
      ncoin = int'(coin5) + int'(coin10) + int'(coin25);
      val   = coin25 ? 25 : coin10 ? 10 : coin5 ? 5 : 0;
      m_reject = 0;
      if (m_vend >= 0) begin
        m_reject = ncoin > 0;
        m_credit -= price[m_vend];
        if (m_stock[m_vend] > 0) m_stock[m_vend]--;
        m_refund = m_credit > 0;
        m_vend = -1;
      end else if (m_refund) begin
        m_reject = ncoin > 0;
        if (change_ack) begin
          m_credit -= greedy(m_credit);
          if (m_credit == 0) m_refund = 0;
        end
      end else if (cancel && m_credit > 0) begin
        m_refund = 1;
        m_reject = ncoin > 0;
      end else if (ncoin > 0) begin
        if (ncoin > 1 || m_credit + val > MAXC) m_reject = 1;
        else m_credit += val;
      end else if (select && int'(sel_id) < NP && m_credit >= price[sel_id] && !empty(int'(sel_id))) begin
        m_vend = int'(sel_id);
      end
      if (restock) foreach (m_stock[i]) m_stock[i] = STOCK_INIT;
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk) begin
    int exp_so;
    exp_so = 0;
    for (int i = 0; i < NP; i++) if (empty(i)) exp_so |= (1 << i);
    check("credit", int'(credit), m_credit);
    check("dispense", int'(dispense), int'(m_vend >= 0));
    if (m_vend >= 0) check("dispense_id", int'(dispense_id), m_vend);
    check("change_valid", int'(change_valid), int'(m_refund));
    if (m_refund) check("change_coin", int'(change_coin), code_of(greedy(m_credit)));
    check("coin_reject", int'(coin_reject), int'(m_reject));
    check("busy", int'(busy), int'(m_vend >= 0 || m_refund));
    check("sold_out", int'(sold_out), exp_so);
  end

  task automatic tick(input string what);
    @(posedge clk);
    #1;
    $display("txn %-22s credit=%0d disp=%0b cv=%0b coin=%0d rej=%0b", what, credit, dispense, change_valid, change_coin, coin_reject);
    coin5 = 0; coin10 = 0; coin25 = 0; select = 0; cancel = 0; restock = 0; change_ack = 0;
  endtask

  task automatic coin(input int v);
    coin5 = (v == 5); coin10 = (v == 10); coin25 = (v == 25);
    tick($sformatf("coin%0d", v));
  endtask

  task automatic sel(input int id);
    select = 1; sel_id = 2'(id);
    tick($sformatf("select %0d", id));
  endtask

  task automatic ack();
    change_ack = 1;
    tick("ack");
  endtask

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;
    check("reset_credit", int'(credit), 0);
    check("reset_sold_out", int'(sold_out), 0);

    // Asynchronous reset in the middle of a cycle while collecting.
    coin(5); coin(10);
    check("lit_credit15", int'(credit), 15);
    #2 reset_n = 0;
    #1;
    check("async_credit", int'(credit), 0);
    check("async_busy", int'(busy), 0);
    check("async_outs", int'({dispense, change_valid, coin_reject, change_coin}), 0);
    @(negedge clk) reset_n = 1;
    @(posedge clk); #1;

    // Exact payment.
    coin(25); sel(1);
    check("exact_dispense", int'(dispense), 1);
    check("exact_id", int'(dispense_id), 1);
    tick("idle");
    check("exact_cv", int'(change_valid), 0);
    check("exact_credit", int'(credit), 0);

    // Overpayment with slow acknowledge.
    coin(25); coin(25); sel(0);
    check("over_dispense", int'(dispense), 1);
    tick("vend done");
    check("over_credit35", int'(credit), 35);
    for (int k = 0; k < 3; k++) begin
      tick("hold");
      check("hold_cv", int'(change_valid), 1);
      check("hold_coin", int'(change_coin), 3);
    end
    ack();
    check("over_coin10", int'(change_coin), 2);
    ack();
    check("over_done", int'(change_valid), 0);

    // Insufficient funds, then cancel.
    coin(10); sel(3);
    check("insuf_disp", int'(dispense), 0);
    check("insuf_credit", int'(credit), 10);
    cancel = 1; tick("cancel");
    check("cancel_coin", int'(change_coin), 2);
    ack();
    check("cancel_credit", int'(credit), 0);

    // Credit bounds and rejections.
    repeat (4) coin(25);
    check("max_credit", int'(credit), 100);
    coin(5);
    check("over_reject", int'(coin_reject), 1);
    check("over_credit", int'(credit), 100);
    coin5 = 1; coin10 = 1; tick("coin5+coin10");
    check("dual_reject", int'(coin_reject), 1);
    cancel = 1; tick("cancel");
    coin(10);
    check("change_reject", int'(coin_reject), 1);
    repeat (4) ack();
    check("bounds_idle", int'(credit), 0);

    // Coin alongside cancel is refused.
    coin(5);
    cancel = 1; coin25 = 1; tick("cancel+coin25");
    check("cc_reject", int'(coin_reject), 1);
    check("cc_coin", int'(change_coin), 1);
    ack();

    // Stock handling for product 2.
    coin(25); coin(10); sel(2);
    check("stock_disp1", int'(dispense), 1);
    tick("vend done");
`ifdef VM_STOCK_EN
    check("sold_out2", int'(sold_out[2]), 1);
    coin(25); coin(10); sel(2);
    check("soldout_ignored", int'(dispense), 0);
    restock = 1; tick("restock");
    check("restocked", int'(sold_out[2]), 0);
    sel(2);
    check("stock_disp2", int'(dispense), 1);
    tick("vend done");
`else
    check("no_stock_so", int'(sold_out), 0);
    coin(25); coin(10); sel(2);
    check("unlimited_disp", int'(dispense), 1);
    tick("vend done");
    restock = 1; tick("restock");
`endif
    check("final_credit", int'(credit), 0);
    tick("idle");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
